random_range_gen: RTL and testbench
===================================

Name: random_range_gen

Overview:
- Parametrised successor to the 4-bit free-running random number generator.
- Two selectable sources: a Galois LFSR of configurable width and a wrap-around counter.
- Results are restricted to 0..MAX_VALUE by rejection and delivered through a one-entry valid/ready output register.
- Consumers are game and test logic needing bounded pseudo-random values with back-pressure and a reloadable seed.

Parameters:
- WIDTH, 8: LFSR state width in bits, legal range 4..16.
- TAPS, 8'hB8: Galois feedback mask, WIDTH bits wide. The default is maximal-length for WIDTH=8, period 255.
- SEED, 1: LFSR reset value. A value of 0 is illegal and is replaced by 1.
- MAX_VALUE, 10: inclusive upper bound of delivered values. Requires MAX_VALUE < 2**WIDTH.
- OUT_W, derived as $clog2(MAX_VALUE+1): width of rnd_data. It is a localparam, not overridable.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: advances the selected generator each cycle it is high.
- mode, input, 1: 0 selects counter, 1 selects LFSR.
- seed_load, input, 1: synchronous seed reload, one-cycle pulse.
- seed_in, input, WIDTH: seed value used with seed_load.
- rnd_ready, input, 1: consumer accepts rnd_data.
- rnd_valid, output, 1: rnd_data holds an unconsumed value.
- rnd_data, output, OUT_W: bounded random value.
- lfsr_state, output, WIDTH: current LFSR state, for debug.

Behaviour:
- Reset (reset_n low, asynchronous):
  - lfsr <= SEED, or 1 if SEED is 0.
  - cnt <= 0.
  - rnd_valid <= 0 and rnd_data <= 0.
  - Reset asserted mid-operation discards any held value immediately.
- LFSR step: next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0). The state is never 0.
- Counter step: next = (cnt == MAX_VALUE) ? 0 : cnt + 1. Width is OUT_W; the counter never exceeds MAX_VALUE.
- Candidate, computed from the current (pre-step) state:
  - mode=1: lfsr[OUT_W-1:0].
  - mode=0: cnt.
  - Accept when candidate <= MAX_VALUE; otherwise reject.
- Slot free = !rnd_valid || rnd_ready.
- Per rising edge with seed_load=0 and enable=1:
  - Only the selected generator steps; the other holds.
  - Slot free and candidate accepted: rnd_data <= candidate, rnd_valid <= 1. Latency is one clock from state to output.
  - Slot free and candidate rejected: rnd_valid <= 0; rnd_data holds its old value.
  - Slot not free (stall): rnd_data and rnd_valid hold. The generator still steps, so values produced during a stall are dropped, not queued.
- enable=0:
  - Generators hold.
  - If rnd_valid && rnd_ready, the value is consumed and rnd_valid <= 0.
  - Otherwise the outputs hold.
- seed_load=1 has priority over enable:
  - lfsr <= seed_in, or 1 if seed_in is 0.
  - cnt <= seed_in[OUT_W-1:0] if that is <= MAX_VALUE, else 0.
  - rnd_valid <= 0; any held value is flushed even if rnd_ready was high.
- A mode change takes effect on the next edge. No flush occurs; the held value stays valid.
- rnd_data must change only on an edge where the slot is free. Stable-while-stalled is a protocol assertion.
- States:
  - EMPTY (rnd_valid=0): moves to FULL on an accepted candidate.
  - FULL (rnd_valid=1): moves to EMPTY on consume with reject, disable, or seed_load. Stays FULL on consume with accept, or on stall.

Test Plan:
1. Reset with defaults, enable=1, mode=1, rnd_ready=1 for 8 edges -> rnd_data/rnd_valid sequence 1/1, 8/1, -/0, -/0, 7/1, 3/1, 1/1, 8/1. lfsr_state runs 01, B8, 5C, 2E, 17, B3, E1, C8, 64.
2. mode=0, rnd_ready=1, enable=1 for 14 edges from reset -> rnd_data 0,1,...,10,0,1,2 with rnd_valid constantly 1.
3. Stall: after the first value (1) is delivered, hold rnd_ready=0 for 3 edges -> rnd_data stays 1 and rnd_valid stays 1. On release, rnd_data equals the candidate of the current lfsr_state, or rnd_valid drops if that candidate is rejected.
4. seed_load with seed_in=0 while rnd_valid=1 and rnd_ready=0 -> next edge gives lfsr_state=01 and rnd_valid=0. The following enabled edge gives rnd_data=1.
5. LFSR period: free-run mode=1 from SEED=1 -> lfsr_state returns to 01 after exactly 255 steps, never reads 00, and every rnd_data is <= 10.
6. Assert reset_n low asynchronously mid-cycle while rnd_valid=1 -> rnd_valid=0, rnd_data=0 and lfsr_state=01 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/random_range_gen.sv
// random_range_gen: bounded pseudo-random values from an LFSR or counter through a valid/ready output slot
module random_range_gen #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter int SEED = 1,
  parameter int MAX_VALUE = 10,
  localparam int OUT_W = (MAX_VALUE > 0) ? $clog2(MAX_VALUE + 1) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_data,
  output logic [WIDTH-1:0] lfsr_state
);
  typedef enum logic {EMPTY, FULL} state_e;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] RST_LFSR = (SEED_W == '0) ? ONE : SEED_W;
  localparam logic [OUT_W-1:0] MAX_V = OUT_W'(MAX_VALUE);
  state_e state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0] cnt_q, cnt_d, data_q, data_d;
  logic [WIDTH-1:0] lfsr_step, seed_lfsr;
  logic [OUT_W-1:0] cnt_step, cand, seed_cnt;
  logic accept, slot_free, take;
  // Generator steps, candidate selection and seed sanitising; a zero seed would lock the LFSR, so it becomes 1
  always_comb begin
    lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    cnt_step  = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
    cand      = mode ? lfsr_q[OUT_W-1:0] : cnt_q;
    accept    = cand <= MAX_V;
    slot_free = (state_q == EMPTY) || rnd_ready;
    seed_lfsr = (seed_in == '0) ? ONE : seed_in;
    seed_cnt  = (seed_in[OUT_W-1:0] <= MAX_V) ? seed_in[OUT_W-1:0] : '0;
    take      = !seed_load && enable && slot_free && accept;
  end
  // Registers: both generators, the output slot state and its held value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      lfsr_q  <= RST_LFSR;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
  // Next state: seed reload wins, only the selected generator steps, stalled values are dropped rather than queued
  always_comb begin
    lfsr_d  = seed_load ? seed_lfsr : (enable && mode) ? lfsr_step : lfsr_q;
    cnt_d   = seed_load ? seed_cnt : (enable && !mode) ? cnt_step : cnt_q;
    data_d  = take ? cand : data_q;
    state_d = seed_load ? EMPTY :
              enable    ? (slot_free ? (accept ? FULL : EMPTY) : state_q) :
              (state_q == FULL && rnd_ready) ? EMPTY : state_q;
  end
  // Outputs come straight from registers
  always_comb begin
    rnd_valid  = state_q == FULL;
    rnd_data   = data_q;
    lfsr_state = lfsr_q;
  end
  // A held value must not change while the consumer is stalling
  assert property (@(posedge clk) disable iff (!reset_n) (rnd_valid && !rnd_ready) |=> $stable(rnd_data))
    else $error("rnd_data changed while stalled");
endmodule

// File: tb/tb_random_range_gen.sv
// tb_random_range_gen: directed vector bench for random_range_gen with default parameters
module tb_random_range_gen;
  logic clk = 0, reset_n = 0, enable = 0, mode = 0, seed_load = 0, rnd_ready = 0;
  logic [7:0] seed_in = '0;
  logic rnd_valid;
  logic [3:0] rnd_data;
  logic [7:0] lfsr_state;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  random_range_gen dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .seed_load(seed_load),
    .seed_in(seed_in), .rnd_ready(rnd_ready), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .lfsr_state(lfsr_state)
  );

  typedef struct {
    logic rst, en, md, sl;
    logic [7:0] sin;
    logic rdy, ev;
    logic [3:0] ed;
    logic [7:0] el;
  } vec_t;
  vec_t v[22];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic drive(input logic en, input logic md, input logic sl, input logic [7:0] sin, input logic rdy);
    enable = en; mode = md; seed_load = sl; seed_in = sin; rnd_ready = rdy;
  endtask

  task automatic edge_chk(input string n, input logic ev, input logic [3:0] ed, input logic [7:0] el);
    @(posedge clk);
    @(negedge clk);
    chk({n, ".valid"}, 32'(rnd_valid), 32'(ev));
    chk({n, ".data"}, 32'(rnd_data), 32'(ed));
    chk({n, ".lfsr"}, 32'(lfsr_state), 32'(el));
  endtask

  task automatic do_reset();
    reset_n = 0;
    drive(0, 0, 0, 8'h00, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, zero, over;
    v[0] = '{1, 1, 1, 0, 8'h00, 1, 1, 4'd1, 8'hB8};
    v[1] = '{0, 1, 1, 0, 8'h00, 1, 1, 4'd8, 8'h5C};
    v[2] = '{0, 1, 1, 0, 8'h00, 1, 0, 4'd8, 8'h2E};
    v[3] = '{0, 1, 1, 0, 8'h00, 1, 0, 4'd8, 8'h17};
    v[4] = '{0, 1, 1, 0, 8'h00, 1, 1, 4'd7, 8'hB3};
    v[5] = '{0, 1, 1, 0, 8'h00, 1, 1, 4'd3, 8'hE1};
    v[6] = '{0, 1, 1, 0, 8'h00, 1, 1, 4'd1, 8'hC8};
    v[7] = '{0, 1, 1, 0, 8'h00, 1, 1, 4'd8, 8'h64};
    for (int k = 0; k < 14; k++)
      v[8 + k] = '{(k == 0), 1, 0, 0, 8'h00, 1, 1, 4'(k % 11), 8'h01};

    do_reset();
    chk("reset.valid", 32'(rnd_valid), 0);
    chk("reset.data", 32'(rnd_data), 0);
    chk("reset.lfsr", 32'(lfsr_state), 32'h01);

    for (int i = 0; i < 22; i++) begin
      if (v[i].rst) do_reset();
      drive(v[i].en, v[i].md, v[i].sl, v[i].sin, v[i].rdy);
      edge_chk($sformatf("vec%0d", i), v[i].ev, v[i].ed, v[i].el);
    end

    // stall keeps the held value while the LFSR keeps stepping
    do_reset();
    drive(1, 1, 0, 8'h00, 1);
    edge_chk("stall.first", 1, 4'd1, 8'hB8);
    drive(1, 1, 0, 8'h00, 0);
    edge_chk("stall.1", 1, 4'd1, 8'h5C);
    edge_chk("stall.2", 1, 4'd1, 8'h2E);
    edge_chk("stall.3", 1, 4'd1, 8'h17);
    drive(1, 1, 0, 8'h00, 1);
    edge_chk("stall.release", 1, 4'd7, 8'hB3);

    // zero seed reload flushes a held value even under stall
    drive(1, 1, 1, 8'h00, 0);
    edge_chk("seed0.load", 0, 4'd7, 8'h01);
    drive(1, 1, 0, 8'h00, 1);
    edge_chk("seed0.next", 1, 4'd1, 8'hB8);

    // counter seeding: out-of-range low bits clear, in-range bits load
    drive(1, 0, 1, 8'h0C, 1);
    edge_chk("seedC.load", 0, 4'd1, 8'h0C);
    drive(1, 0, 0, 8'h00, 1);
    edge_chk("seedC.next", 1, 4'd0, 8'h0C);
    drive(1, 0, 1, 8'h25, 1);
    edge_chk("seed25.load", 0, 4'd0, 8'h25);
    drive(1, 0, 0, 8'h00, 1);
    edge_chk("seed25.next", 1, 4'd5, 8'h25);

    // disabled: hold while stalled, consume when ready, generators frozen
    drive(0, 0, 0, 8'h00, 0);
    edge_chk("dis.hold", 1, 4'd5, 8'h25);
    drive(0, 0, 0, 8'h00, 1);
    edge_chk("dis.consume", 0, 4'd5, 8'h25);
    drive(1, 0, 0, 8'h00, 1);
    edge_chk("dis.resume", 1, 4'd6, 8'h25);

    // full LFSR period from reset
    do_reset();
    drive(1, 1, 0, 8'h00, 1);
    n = 0; zero = 0; over = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (lfsr_state == 8'h00) zero++;
      if (rnd_data > 4'd10) over++;
    end while (lfsr_state != 8'h01 && n < 300);
    chk("period.len", n, 255);
    chk("period.zero", zero, 0);
    chk("period.bound", over, 0);

    // asynchronous reset mid-cycle with a held value
    edge_chk("async.pre", 1, 4'd1, 8'hB8);
    #2 reset_n = 0;
    #1;
    chk("async.valid", 32'(rnd_valid), 0);
    chk("async.data", 32'(rnd_data), 0);
    chk("async.lfsr", 32'(lfsr_state), 32'h01);
    @(negedge clk);
    reset_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
